noc_credit_receiver: RTL and testbench

Terminates one credit-based router output link: the downstream end of the data/dest/is_tail/send flit interface, returning one credit per consumed flit. Buffers flits in a BUFFER_DEPTH FIFO and presents them as a valid/ready flit stream to a local consumer, such as a deserializer shim, a link monitor or a test sink. Also checks link protocol: buffer overflow and a dest change inside a packet. Counts delivered packets.

---
 rtl/noc_link_pkg.sv | 14 +
 rtl/flit_fifo.sv | 67 ++++++
 rtl/noc_credit_receiver.sv | 128 ++++++++++++
 tb/tb_noc_credit_receiver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_link_pkg.sv
// Shared types for the credit-based NoC link receiver.
// Holds the packet-tracking state encoding and pointer sizing helper.
package noc_link_pkg;

  typedef enum logic {
    RX_IDLE   = 1'b0,
    RX_IN_PKT = 1'b1
  } rx_state_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// First-word fall-through flit buffer with arbitrary (non power-of-2) depth.
// A pop frees a slot in the same cycle, so push at full is legal with pop.
module flit_fifo
  import noc_link_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int PW   = ptr_w(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop_ok;
  logic          push_ok;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = inc(wr_q);
    if (pop_ok)  rd_d = inc(rd_q);
    if (push_ok && !pop_ok) cnt_d = cnt_q + CW'(1);
    if (pop_ok && !push_ok) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/noc_credit_receiver.sv
// Downstream end of a credit-based router link: buffers flits, returns
// one credit per consumed flit, checks link protocol, counts packets.
module noc_credit_receiver
  import noc_link_pkg::*;
#(
  parameter int FLIT_WIDTH      = 32,
  parameter int DEST_WIDTH      = 4,
  parameter int BUFFER_DEPTH    = 2,
  parameter int PKT_COUNT_WIDTH = 16
) (
  input  logic                       clk_noc,
  input  logic                       rst_noc,
  input  logic [FLIT_WIDTH-1:0]      data_in,
  input  logic [DEST_WIDTH-1:0]      dest_in,
  input  logic                       is_tail_in,
  input  logic                       send_in,
  output logic                       credit_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FLIT_WIDTH-1:0]      out_data,
  output logic [DEST_WIDTH-1:0]      out_dest,
  output logic                       out_last,
  output logic                       err_overflow,
  output logic                       err_dest_change,
  input  logic                       err_clear,
  output logic [PKT_COUNT_WIDTH-1:0] pkt_count
);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
  } flit_t;

  localparam int FW = $bits(flit_t);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);

  flit_t         wr_flit;
  flit_t         rd_flit;
  logic          f_full;
  logic          f_empty;
  logic [CW-1:0] f_count;
  logic          pop;
  logic          ovf_ev;
  logic          dc_ev;

  rx_state_e             st_q, st_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic                  credit_q;
  logic                  ovf_q, ovf_d;
  logic                  dc_q, dc_d;
  logic [PKT_COUNT_WIDTH-1:0] pkt_q, pkt_d;

  assign wr_flit = '{data: data_in, dest: dest_in, is_tail: is_tail_in};

  flit_fifo #(
    .W     (FW),
    .DEPTH (BUFFER_DEPTH)
  ) u_fifo (
    .clk_i   (clk_noc),
    .rst_i   (rst_noc),
    .push_i  (send_in),
    .pop_i   (pop),
    .wdata_i (wr_flit),
    .rdata_o (rd_flit),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count)
  );

  assign out_valid = (f_count != '0);
  assign pop       = !f_empty && out_ready;
  assign out_data  = rd_flit.data;
  assign out_dest  = rd_flit.dest;
  assign out_last  = rd_flit.is_tail;

  assign ovf_ev = send_in && f_full && !pop;
  assign dc_ev  = send_in && (st_q == RX_IN_PKT) && (dest_in != dest_q);

  // Dropped flits still advance packet tracking.
  always_comb begin
    st_d   = st_q;
    dest_d = dest_q;
    unique case (st_q)
      RX_IDLE: begin
        if (send_in) begin
          dest_d = dest_in;
          if (!is_tail_in) st_d = RX_IN_PKT;
        end
      end
      RX_IN_PKT: begin
        if (send_in && is_tail_in) st_d = RX_IDLE;
      end
      default: st_d = RX_IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_ev || (ovf_q && !err_clear);
    dc_d  = dc_ev || (dc_q && !err_clear);
    pkt_d = pkt_q;
    if (pop && rd_flit.is_tail) pkt_d = pkt_q + PKT_COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      st_q     <= RX_IDLE;
      dest_q   <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
      dc_q     <= 1'b0;
      pkt_q    <= '0;
    end else begin
      st_q     <= st_d;
      dest_q   <= dest_d;
      credit_q <= pop;
      ovf_q    <= ovf_d;
      dc_q     <= dc_d;
      pkt_q    <= pkt_d;
    end
  end

  assign credit_out      = credit_q;
  assign err_overflow    = ovf_q;
  assign err_dest_change = dc_q;
  assign pkt_count       = pkt_q;

endmodule

// File: tb/tb_noc_credit_receiver.sv
// Directed bench for noc_credit_receiver with a flit scoreboard
// and a behavioural model of credits, errors and packet count.
module tb_noc_credit_receiver;

  localparam int FW = 32;
  localparam int DW = 4;
  localparam int D  = 2;
  localparam int PW = 16;

  logic          clk_noc;
  logic          rst_noc;
  logic [FW-1:0] data_in;
  logic [DW-1:0] dest_in;
  logic          is_tail_in;
  logic          send_in;
  logic          credit_out;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] out_data;
  logic [DW-1:0] out_dest;
  logic          out_last;
  logic          err_overflow;
  logic          err_dest_change;
  logic          err_clear;
  logic [PW-1:0] pkt_count;

  noc_credit_receiver #(
    .FLIT_WIDTH      (FW),
    .DEST_WIDTH      (DW),
    .BUFFER_DEPTH    (D),
    .PKT_COUNT_WIDTH (PW)
  ) dut (
    .clk_noc         (clk_noc),
    .rst_noc         (rst_noc),
    .data_in         (data_in),
    .dest_in         (dest_in),
    .is_tail_in      (is_tail_in),
    .send_in         (send_in),
    .credit_out      (credit_out),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_dest        (out_dest),
    .out_last        (out_last),
    .err_overflow    (err_overflow),
    .err_dest_change (err_dest_change),
    .err_clear       (err_clear),
    .pkt_count       (pkt_count)
  );

  initial clk_noc = 1'b0;
  always #5 clk_noc = ~clk_noc;

  typedef struct {
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    logic          tail;
  } flit_s;

  flit_s         sb[$];
  int            nvec = 0;
  int            nerr = 0;
  logic          m_ovf, m_dc, m_credit, m_inpkt;
  logic [DW-1:0] m_dest;
  logic [PW-1:0] m_pkt;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ovf    = 1'b0;
    m_dc     = 1'b0;
    m_credit = 1'b0;
    m_inpkt  = 1'b0;
    m_dest   = '0;
    m_pkt    = '0;
  endtask

  task automatic drive(input logic s, input logic [FW-1:0] d,
                       input logic [DW-1:0] de, input logic t);
    send_in    = s;
    data_in    = d;
    dest_in    = de;
    is_tail_in = t;
  endtask

  // One clock: check head, apply edge, check registered outputs.
  task automatic tick(input string tag);
    logic  pop_m, acc, ovf_ev, dc_ev;
    flit_s h;
    chk({tag, ".valid"}, 64'(out_valid), 64'(sb.size() != 0));
    pop_m = out_ready && (sb.size() != 0);
    if (sb.size() != 0) begin
      h = sb[0];
      chk({tag, ".data"}, 64'(out_data), 64'(h.data));
      chk({tag, ".dest"}, 64'(out_dest), 64'(h.dest));
      chk({tag, ".last"}, 64'(out_last), 64'(h.tail));
    end
    acc    = send_in && ((sb.size() < D) || pop_m);
    ovf_ev = send_in && !acc;
    dc_ev  = send_in && m_inpkt && (dest_in != m_dest);
    if (pop_m) begin
      h = sb.pop_front();
      if (h.tail) m_pkt = m_pkt + PW'(1);
    end
    if (acc) sb.push_back('{data_in, dest_in, is_tail_in});
    if (send_in) begin
      if (!m_inpkt) begin
        m_dest  = dest_in;
        m_inpkt = !is_tail_in;
      end else if (is_tail_in) begin
        m_inpkt = 1'b0;
      end
    end
    m_ovf    = ovf_ev || (m_ovf && !err_clear);
    m_dc     = dc_ev || (m_dc && !err_clear);
    m_credit = pop_m;
    @(posedge clk_noc);
    #1;
    chk({tag, ".credit"}, 64'(credit_out), 64'(m_credit));
    chk({tag, ".ovf"}, 64'(err_overflow), 64'(m_ovf));
    chk({tag, ".dc"}, 64'(err_dest_change), 64'(m_dc));
    chk({tag, ".pkt"}, 64'(pkt_count), 64'(m_pkt));
  endtask

  initial begin
    int n;
    rst_noc   = 1'b1;
    out_ready = 1'b0;
    err_clear = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk_noc);
    #1;
    rst_noc = 1'b0;
    chk("rst.valid", 64'(out_valid), 64'(0));
    chk("rst.credit", 64'(credit_out), 64'(0));
    chk("rst.ovf", 64'(err_overflow), 64'(0));
    chk("rst.dc", 64'(err_dest_change), 64'(0));
    chk("rst.pkt", 64'(pkt_count), 64'(0));

    // Single-flit packet, ready consumer
    out_ready = 1'b1;
    drive(1'b1, 32'hA5A5_0001, 4'h5, 1'b1);
    tick("single.push");
    drive(1'b0, '0, '0, 1'b0);
    tick("single.pop");
    chk("single.pkt1", 64'(pkt_count), 64'(1));
    tick("single.idle");

    // Overflow with stalled consumer
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1000 + 32'(i), 4'h2, 1'b1);
      tick("ovf.fill");
    end
    chk("ovf.sticky", 64'(err_overflow), 64'(1));
    drive(1'b0, '0, '0, 1'b0);
    tick("ovf.hold");
    out_ready = 1'b1;
    repeat (3) tick("ovf.drain");

    // Dest change inside a packet
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h2000 + 32'(i), (i == 3) ? 4'h7 : 4'h3, i == 3);
      tick("dc.pkt");
    end
    chk("dc.sticky", 64'(err_dest_change), 64'(1));
    drive(1'b0, '0, '0, 1'b0);
    err_clear = 1'b1;
    tick("dc.clear");
    err_clear = 1'b0;
    chk("dc.cleared", 64'(err_dest_change), 64'(0));
    chk("ovf.cleared", 64'(err_overflow), 64'(0));
    tick("dc.drain");

    // Full FIFO with simultaneous push and pop, then overflow vs clear
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h3000 + 32'(i), 4'h9, 1'b1);
      tick("full.fill");
    end
    out_ready = 1'b1;
    drive(1'b1, 32'h3002, 4'h9, 1'b1);
    tick("full.pushpop");
    chk("full.noovf", 64'(err_overflow), 64'(0));
    chk("full.count", 64'(sb.size()), 64'(2));
    out_ready = 1'b0;
    err_clear = 1'b1;
    drive(1'b1, 32'h3003, 4'h9, 1'b1);
    tick("full.errwins");
    err_clear = 1'b0;
    chk("full.errwins_set", 64'(err_overflow), 64'(1));
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    repeat (3) tick("full.drain");

    // Streaming one flit per cycle through pkt_count wrap
    n = 65536 - int'(m_pkt) + 3;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 32'(i) ^ 32'h5A5A_0000, 4'(i), 1'b1);
      tick("stream");
    end
    drive(1'b0, '0, '0, 1'b0);
    tick("stream.tail");
    chk("stream.wrap", 64'(pkt_count), 64'(3));

    // Asynchronous reset mid-packet with two flits buffered
    drive(1'b1, 32'h4000, 4'h1, 1'b0);
    out_ready = 1'b0;
    tick("rst.p0");
    drive(1'b1, 32'h4001, 4'h1, 1'b0);
    tick("rst.p1");
    out_ready = 1'b1;
    drive(1'b1, 32'h4002, 4'h1, 1'b0);
    tick("rst.p2");
    chk("rst.pre_credit", 64'(credit_out), 64'(1));
    drive(1'b0, '0, '0, 1'b0);
    out_ready = 1'b0;
    #2;
    rst_noc = 1'b1;
    #1;
    chk("arst.valid", 64'(out_valid), 64'(0));
    chk("arst.credit", 64'(credit_out), 64'(0));
    model_reset();
    @(posedge clk_noc);
    #3;
    rst_noc = 1'b0;
    @(posedge clk_noc);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h5000 + 32'(i), 4'hC, i == 1);
      tick("post.pkt");
    end
    drive(1'b0, '0, '0, 1'b0);
    tick("post.drain");
    chk("post.nodc", 64'(err_dest_change), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
